// File: rtl/mem_resp.sv
// Wait-stated 8x8 register-file responder for a cache-side initiator.
// Four-phase req/ack handshake; debug taps expose state and every word.
module mem_resp #(
  parameter int unsigned WAIT      = 2,
  parameter logic [7:0]  INIT_BASE = 8'hA0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] ram0,
  output logic [7:0] ram1,
  output logic [7:0] ram2,
  output logic [7:0] ram3,
  output logic [7:0] ram4,
  output logic [7:0] ram5,
  output logic [7:0] ram6,
  output logic [7:0] ram7
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ACC  = 3'd2,
    S_ACK  = 3'd3
  } state_t;

  localparam logic [3:0] WAIT_L = 4'(WAIT);

  state_t     st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mem_q [8];

  logic [7:0] a_q;
  logic       rw_q;
  logic [7:0] wd_q;

  logic [7:0] rdata_q, rdata_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;

  logic       lat;
  logic       we;
  logic       a_ok;

  assign a_ok = (a_q[7:3] == 5'd0);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    err_d   = err_q;
    lat     = 1'b0;
    we      = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (req) begin
          lat   = 1'b1;
          cnt_d = WAIT_L;
          st_d  = (WAIT_L == 4'd0) ? S_ACC : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) st_d = S_ACC;
      end
      S_ACC: begin
        st_d = S_ACK;
        if (a_ok) begin
          we      = rw_q;
          err_d   = 1'b0;
          rdata_d = rw_q ? wd_q : mem_q[a_q[2:0]];
        end else begin
          err_d   = 1'b1;
          rdata_d = 8'h00;
        end
      end
      S_ACK: begin
        // ack comes up on the first ACK edge, then waits for req low
        if (!ack_q) begin
          ack_d = 1'b1;
        end else if (!req) begin
          ack_d = 1'b0;
          err_d = 1'b0;
          st_d  = S_IDLE;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      st_q    <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= 8'h00;
      rw_q    <= 1'b0;
      wd_q    <= 8'h00;
      for (int i = 0; i < 8; i++)
        mem_q[i] <= INIT_BASE + 8'(i);
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (lat) begin
        a_q  <= addr;
        rw_q <= rw;
        wd_q <= wdata;
      end
      if (we) mem_q[a_q[2:0]] <= wd_q;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = (st_q != S_IDLE);
  assign state = st_q;

  assign ram0 = mem_q[0];
  assign ram1 = mem_q[1];
  assign ram2 = mem_q[2];
  assign ram3 = mem_q[3];
  assign ram4 = mem_q[4];
  assign ram5 = mem_q[5];
  assign ram6 = mem_q[6];
  assign ram7 = mem_q[7];

endmodule
